ghash_ctrl: RTL and testbench
=============================

# ghash_ctrl

Sequencing controller for the GF(2^128) multiplier in the AES-GCM authentication path. It holds the hash subkey H and the running GHASH accumulator Y. Each accepted 128-bit block X is folded in as Y = (Y ^ X) · H, issued to the multiplier, and the controller waits for the product before taking the next block. On the last block of a message it emits the tag and clears Y for the next message.

## Interface
Parameters:
- WDT_CYCLES, 64: watchdog limit, in cycles, for a multiplier response. Used only when GHASH_WDT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- h_valid_i  in  1  load H from h_i
- h_i  in  128  hash subkey
- init_i  in  1  clear Y and err_o
- blk_valid_i  in  1  block X present
- blk_ready_o  out  1  controller accepts X this cycle
- blk_i  in  128  block X
- blk_last_i  in  1  X is the final block of the message
- mul_valid_o  out  1  one-cycle issue strobe to the multiplier
- mul_a_o  out  128  operand A = Y ^ X
- mul_b_o  out  128  operand B = H
- mul_valid_i  in  1  multiplier result valid
- mul_result_i  in  128  multiplier result
- tag_valid_o  out  1  one-cycle tag strobe
- tag_o  out  128  final Y of the message
- busy_o  out  1  multiply in flight
- err_o  out  1  sticky watchdog error

## Operation
- State machine has two states. IDLE is the reset state; WAIT means a multiply is outstanding.
- Internal state at reset: H = 0, h_loaded = 0, Y = 0, last_q = 0, watchdog counter = 0.
- Every output resets to 0.
- blk_ready_o = (state == IDLE) && h_loaded && !h_valid_i && !init_i. It is combinational.
- IDLE, h_valid_i = 1: H ← h_i, h_loaded ← 1, Y ← 0.
- IDLE, init_i = 1: Y ← 0, err_o ← 0.
- If h_valid_i and init_i are high together, both actions apply.
- In WAIT, h_valid_i and init_i are ignored and have no effect.
- Handshake: X is accepted when blk_valid_i && blk_ready_o. On acceptance:
  - mul_a_o ← Y ^ blk_i, mul_b_o ← H, mul_valid_o ← 1 for the next cycle only;
  - last_q ← blk_last_i;
  - state ← WAIT.
- mul_a_o and mul_b_o are registered and hold their values until the next issue.
- WAIT, mul_valid_i = 1: Y ← mul_result_i, then state ← IDLE.
  - If last_q = 1: tag_o ← mul_result_i, tag_valid_o pulses for one cycle, and Y ← 0 instead of the result.
- mul_valid_i in IDLE is ignored.
- busy_o = (state == WAIT).
- The multiplier returns results in order, one per issue, with fixed latency L ≥ 1. The controller does not depend on the value of L.

## Timing
- Block accepted at edge t (cycle t is the cycle with the valid/ready handshake):
  - mul_valid_o is high in cycle t+1;
  - the multiplier raises mul_valid_i in cycle t+1+L;
  - blk_ready_o can be high again in cycle t+2+L;
  - for a last block, tag_valid_o is high in cycle t+2+L.
- Throughput is one block per L+2 cycles. GHASH is a serial dependency chain, so no more than one multiply is ever in flight.
- tag_o holds its value until the next tag.
- Reset asserted mid-WAIT returns every register to its reset value immediately. H must be reloaded afterwards.
- The multiplier must be reset together with the controller, so no stale mul_valid_i is ever consumed.

## Configuration
- GHASH_WDT_EN defined:
  - The counter is $clog2(WDT_CYCLES+1) bits wide. It clears on issue and increments each WAIT cycle that has no mul_valid_i.
  - When it reaches WDT_CYCLES: err_o ← 1 (sticky), Y ← 0, last_q ← 0, state ← IDLE, and no tag is produced.
  - err_o clears only on init_i or reset.
- GHASH_WDT_EN undefined: no counter, err_o is tied to 0, and WAIT lasts until mul_valid_i.

## Test plan
The bench uses a reference GF(2^128) multiplier model with L = 3.
- Single-block message. After reset, load H = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, then send X = 128'h0388dace60b6a392f328c2b971b2fe78 with last = 1.
  - Required: mul_valid_o in cycle t+1, with mul_a_o = X and mul_b_o = H.
  - Required: tag_valid_o in cycle t+5, with tag_o = model(X, H).
  - Required: blk_ready_o high again in cycle t+5.
- Two-block message X1, X2 (last on X2).
  - Required: the second issue has mul_a_o = model(X1, H) ^ X2.
  - Required: exactly one tag_valid_o pulse; Y is 0 afterwards.
- Block before any H load: hold blk_valid_i = 1 for 10 cycles.
  - Required: blk_ready_o = 0 and mul_valid_o = 0 throughout.
- h_valid_i and blk_valid_i in the same IDLE cycle, with new H' = 128'h1.
  - Required: that cycle has blk_ready_o = 0.
  - Required: the block is accepted the next cycle with mul_b_o = 128'h1.
- GHASH_WDT_EN with WDT_CYCLES = 8: issue a block and withhold mul_valid_i.
  - Required: err_o = 1 and busy_o = 0 eight WAIT cycles after issue, with no tag.
  - Required: init_i clears err_o.
- Reset pulsed during WAIT.
  - Required: all outputs are 0 and blk_ready_o stays 0 until H is reloaded.

Source files
------------

// File: rtl/ghash_ctrl.sv
// ghash_ctrl: sequencing controller for the GF(2^128) multiplier in the AES-GCM
// authentication path. Holds the hash subkey H and the running accumulator Y;
// each accepted block X is issued to the multiplier as (Y ^ X, H), and the
// controller waits for the product before accepting the next block.
//
// Optional feature macro: GHASH_WDT_EN enables a response watchdog of
// WDT_CYCLES cycles that aborts a stalled multiply and sets a sticky err_o.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | no multiply outstanding; may accept a block
// ST_WAIT | multiply issued, waiting for mul_valid_i
module ghash_ctrl #(
    parameter int WDT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         h_valid_i,
    input  logic [127:0] h_i,
    input  logic         init_i,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [127:0] blk_i,
    input  logic         blk_last_i,
    output logic         mul_valid_o,
    output logic [127:0] mul_a_o,
    output logic [127:0] mul_b_o,
    input  logic         mul_valid_i,
    input  logic [127:0] mul_result_i,
    output logic         tag_valid_o,
    output logic [127:0] tag_o,
    output logic         busy_o,
    output logic         err_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t       state;
    logic [127:0] h_key;
    logic         h_loaded;
    logic [127:0] y_acc;
    logic         last_q;
    logic         accept;

    // A zero watchdog limit would abort every multiply before it could return.
    if (WDT_CYCLES < 1) begin : g_bad_wdt
        $error("ghash_ctrl: WDT_CYCLES must be at least 1");
    end

`ifdef GHASH_WDT_EN
    localparam int CW = $clog2(WDT_CYCLES + 1);
    localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);
    logic [CW-1:0] wdt_cnt;
`else
    assign err_o = 1'b0;
`endif

    // A new H or an init in the same cycle must land before the block is
    // combined with Y, so both hold off acceptance for that cycle.
    assign blk_ready_o = (state == ST_IDLE) && h_loaded && !h_valid_i && !init_i;
    assign accept      = blk_valid_i && blk_ready_o;
    assign busy_o      = (state == ST_WAIT);

    // Controller state, key/accumulator registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            h_key       <= '0;
            h_loaded    <= 1'b0;
            y_acc       <= '0;
            last_q      <= 1'b0;
            mul_valid_o <= 1'b0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            tag_valid_o <= 1'b0;
            tag_o       <= '0;
`ifdef GHASH_WDT_EN
            err_o       <= 1'b0;
            wdt_cnt     <= '0;
`endif
        end else begin
            mul_valid_o <= 1'b0;
            tag_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (h_valid_i) begin
                        h_key    <= h_i;
                        h_loaded <= 1'b1;
                        y_acc    <= '0;
                    end
                    if (init_i) begin
                        y_acc <= '0;
`ifdef GHASH_WDT_EN
                        err_o <= 1'b0;
`endif
                    end
                    if (accept) begin
                        mul_a_o     <= y_acc ^ blk_i;
                        mul_b_o     <= h_key;
                        mul_valid_o <= 1'b1;
                        last_q      <= blk_last_i;
                        state       <= ST_WAIT;
`ifdef GHASH_WDT_EN
                        wdt_cnt     <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (mul_valid_i) begin
                        state <= ST_IDLE;
                        if (last_q) begin
                            tag_o       <= mul_result_i;
                            tag_valid_o <= 1'b1;
                            y_acc       <= '0;
                        end else begin
                            y_acc <= mul_result_i;
                        end
                    end
`ifdef GHASH_WDT_EN
                    // The abort fires on the edge the count reaches the limit,
                    // so WAIT lasts exactly WDT_CYCLES cycles on a stall.
                    else if (wdt_cnt == WDT_LAST) begin
                        wdt_cnt <= wdt_cnt + 1'b1;
                        err_o   <= 1'b1;
                        y_acc   <= '0;
                        last_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        wdt_cnt <= wdt_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghash_ctrl.sv
// tb_ghash_ctrl: directed bench for ghash_ctrl with a latency-3 reference
// GF(2^128) multiplier. Inputs are driven and outputs sampled just after the
// falling clock edge.
module tb_ghash_ctrl;

    localparam int L = 3;

    localparam logic [127:0] H0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] XA = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] XB = 128'hf7a3b5e0c1d2a4968c7e6b5a49382716;
    localparam logic [127:0] XC = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] XD = 128'hdeadbeef00000000cafef00d12345678;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         h_valid_i = 1'b0;
    logic [127:0] h_i = '0;
    logic         init_i = 1'b0;
    logic         blk_valid_i = 1'b0;
    logic         blk_ready_o;
    logic [127:0] blk_i = '0;
    logic         blk_last_i = 1'b0;
    logic         mul_valid_o;
    logic [127:0] mul_a_o;
    logic [127:0] mul_b_o;
    logic         mul_valid_i = 1'b0;
    logic [127:0] mul_result_i = '0;
    logic         tag_valid_o;
    logic [127:0] tag_o;
    logic         busy_o;
    logic         err_o;

    int n_chk = 0;
    int n_pass = 0;
    int tag_cnt = 0;
    int cd = 0;
    bit withhold = 1'b0;

    always #5 clk = ~clk;

    ghash_ctrl #(.WDT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .h_valid_i    (h_valid_i),
        .h_i          (h_i),
        .init_i       (init_i),
        .blk_valid_i  (blk_valid_i),
        .blk_ready_o  (blk_ready_o),
        .blk_i        (blk_i),
        .blk_last_i   (blk_last_i),
        .mul_valid_o  (mul_valid_o),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .mul_valid_i  (mul_valid_i),
        .mul_result_i (mul_result_i),
        .tag_valid_o  (tag_valid_o),
        .tag_o        (tag_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    // GCM bit-reflected GF(2^128) multiply (right-shift algorithm).
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] h);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = h;
        for (int i = 127; i >= 0; i--) begin
            if (x[i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'he1, 120'h0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    // Reference multiplier: result strobe L cycles after the issue strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            cd = 0;
            mul_valid_i = 1'b0;
        end else begin
            if (tag_valid_o) tag_cnt++;
            mul_valid_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) mul_valid_i = 1'b1;
            end
            if (mul_valid_o && !withhold) begin
                cd = L;
                mul_result_i = gmul(mul_a_o, mul_b_o);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // One block through the full issue/result cycle with fixed latency L.
    task automatic send(input logic [127:0] x, input logic last, input logic [127:0] exp_a,
                        input logic [127:0] exp_b, input logic [127:0] exp_tag, input string nm);
        tick;
        blk_i = x;
        blk_last_i = last;
        blk_valid_i = 1'b1;
        #1;
        chk({nm, "_ready_t"}, blk_ready_o, 1);
        tick;
        blk_valid_i = 1'b0;
        chk({nm, "_issue"}, {mul_valid_o, busy_o}, 2'b11);
        chk({nm, "_mul_a"}, mul_a_o, exp_a);
        chk({nm, "_mul_b"}, mul_b_o, exp_b);
        for (int k = 2; k <= L + 1; k++) begin
            tick;
            chk({nm, "_wait"}, {mul_valid_o, tag_valid_o, busy_o}, 3'b001);
        end
        tick;
        chk({nm, "_tag_valid"}, tag_valid_o, last);
        if (last) chk({nm, "_tag"}, tag_o, exp_tag);
        chk({nm, "_ready_again"}, {blk_ready_o, busy_o}, 2'b10);
    endtask

    typedef struct {
        logic hv;
        logic in;
        logic bv;
        logic exp_rdy;
    } rdy_vec_t;

    initial begin
        rdy_vec_t vecs [8];
        logic [127:0] y1;
        logic [127:0] keep_tag;
        int bad;
        int tc0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0};

        // Reset values.
        tick;
        tick;
        chk("rst_ready", blk_ready_o, 0);
        chk("rst_strobes", {mul_valid_o, tag_valid_o, busy_o, err_o}, 4'b0000);
        chk("rst_mul_a", mul_a_o, 0);
        chk("rst_mul_b", mul_b_o, 0);
        chk("rst_tag", tag_o, 0);
        rst_n = 1'b1;

        // Block offered before any H load.
        tick;
        blk_i = XA;
        blk_valid_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (blk_ready_o || mul_valid_o) bad++;
        end
        blk_valid_i = 1'b0;
        chk("no_h_blocked", bad, 0);

        // Load H.
        tick;
        h_i = H0;
        h_valid_i = 1'b1;
        tick;
        h_valid_i = 1'b0;

        // Ready decode; inputs withdrawn before the next rising edge.
        foreach (vecs[i]) begin
            tick;
            h_valid_i = vecs[i].hv;
            init_i = vecs[i].in;
            blk_valid_i = vecs[i].bv;
            #1;
            chk($sformatf("ready_vec%0d", i), blk_ready_o, vecs[i].exp_rdy);
            #1;
            h_valid_i = 1'b0;
            init_i = 1'b0;
            blk_valid_i = 1'b0;
        end

        // Single-block message.
        send(XA, 1'b1, XA, H0, gmul(XA, H0), "single");

        // Two-block message, then a fresh message proves Y was cleared.
        tc0 = tag_cnt;
        y1 = gmul(XB, H0);
        send(XB, 1'b0, XB, H0, '0, "two_b1");
        send(XC, 1'b1, y1 ^ XC, H0, gmul(y1 ^ XC, H0), "two_b2");
        keep_tag = gmul(y1 ^ XC, H0);
        tick;
        tick;
        chk("two_tag_pulses", tag_cnt - tc0, 1);
        chk("tag_hold", tag_o, keep_tag);
        send(XD, 1'b1, XD, H0, gmul(XD, H0), "after_tag");

        // init mid-message discards the partial accumulator.
        send(XB, 1'b0, XB, H0, '0, "init_b1");
        tick;
        init_i = 1'b1;
        tick;
        init_i = 1'b0;
        send(XC, 1'b1, XC, H0, gmul(XC, H0), "init_b2");

        // H load and block in the same cycle.
        tick;
        h_i = 128'h1;
        h_valid_i = 1'b1;
        blk_i = XD;
        blk_last_i = 1'b1;
        blk_valid_i = 1'b1;
        #1;
        chk("hblk_ready_low", blk_ready_o, 0);
        tick;
        h_valid_i = 1'b0;
        #1;
        chk("hblk_ready_next", blk_ready_o, 1);
        tick;
        blk_valid_i = 1'b0;
        chk("hblk_issue", mul_valid_o, 1);
        chk("hblk_mul_b", mul_b_o, 128'h1);
        chk("hblk_mul_a", mul_a_o, XD);
        for (int k = 0; k < L + 1; k++) tick;
        chk("hblk_tag", {tag_valid_o, tag_o}, {1'b1, gmul(XD, 128'h1)});

        // Stalled multiplier.
        withhold = 1'b1;
        tc0 = tag_cnt;
        tick;
        blk_i = XA;
        blk_last_i = 1'b1;
        blk_valid_i = 1'b1;
        tick;
        blk_valid_i = 1'b0;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            if (!busy_o || err_o) bad++;
            if (k < 8) tick;
        end
        chk("stall_busy_8", bad, 0);
        tick;
`ifdef GHASH_WDT_EN
        chk("wdt_err", {err_o, busy_o}, 2'b10);
        chk("wdt_no_tag", tag_cnt - tc0, 0);
        chk("wdt_ready", blk_ready_o, 1);
        tick;
        init_i = 1'b1;
        tick;
        init_i = 1'b0;
        #1;
        chk("wdt_init_clears", err_o, 0);
        tick;
        blk_valid_i = 1'b1;
        tick;
        blk_valid_i = 1'b0;
`else
        chk("nowdt_still_wait", {err_o, busy_o}, 2'b01);
        chk("nowdt_no_tag", tag_cnt - tc0, 0);
`endif

        // Reset in WAIT.
        tick;
        chk("pre_rst_busy", busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {blk_ready_o, mul_valid_o, tag_valid_o, busy_o, err_o}, 5'b00000);
        chk("mid_rst_mul_a", mul_a_o, 0);
        chk("mid_rst_mul_b", mul_b_o, 0);
        chk("mid_rst_tag", tag_o, 0);
        tick;
        rst_n = 1'b1;
        withhold = 1'b0;
        blk_i = XB;
        blk_valid_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (blk_ready_o || mul_valid_o) bad++;
        end
        blk_valid_i = 1'b0;
        chk("post_rst_no_h", bad, 0);
        tick;
        h_i = H0;
        h_valid_i = 1'b1;
        tick;
        h_valid_i = 1'b0;
        send(XB, 1'b1, XB, H0, gmul(XB, H0), "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
